// File: rtl/vga_line_fetcher.sv
// rtl/vga_line_fetcher.sv - fetches one SDRAM row into a line-cache half on a toggle request
//
// Purpose:
//   Responder for the VGA frame generator's line-fetch toggle handshake. On each accepted request it
//   reads LINE_WORDS words from SDRAM row g_sdram_row in BURST_LEN-word bursts (one outstanding),
//   writes them to the line cache half g_cache_row, then toggles g_ack.
//   Optional build macro: LINE_FETCH_CDC_EN adds a 2-flop synchroniser on g_req.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   g_req / g_ack           request / acknowledge toggles (pending while they differ)
//   g_cache_row             destination cache half (line buffer address bit 10)
//   g_sdram_row             source SDRAM row
//   sd_rd_req / sd_rd_ack   burst read request / acceptance
//   sd_addr                 burst start address {row, col}
//   sd_rd_valid/sd_rd_data  read data stream
//   wr_en/wr_address/wr_data line cache write port
//   busy                    high from acceptance until g_ack toggles
module vga_line_fetcher #(
   parameter int LINE_WORDS = 752,
   parameter int BURST_LEN  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        g_req,
   output logic        g_ack,
   input  logic        g_cache_row,
   input  logic [9:0]  g_sdram_row,
   output logic        sd_rd_req,
   input  logic        sd_rd_ack,
   output logic [19:0] sd_addr,
   input  logic        sd_rd_valid,
   input  logic [15:0] sd_rd_data,
   output logic        wr_en,
   output logic [10:0] wr_address,
   output logic [15:0] wr_data,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   localparam logic [10:0] LINE_WORDS_W = 11'(LINE_WORDS);
   localparam logic [9:0]  BURST_STEP   = 10'(BURST_LEN);
   localparam logic [6:0]  BURST_LAST   = 7'(BURST_LEN - 1);

   state_t      state_q;
   logic        g_ack_q, ack_val_q, row_sel_q, busy_q;
   logic        sd_rd_req_q, wr_en_q;
   logic [9:0]  row_addr_q, col_q, wcnt_q;
   logic [6:0]  bcnt_q;
   logic [19:0] sd_addr_q;
   logic [10:0] wr_address_q;
   logic [15:0] wr_data_q;

   logic        req_s;
   logic        pending, word_accept, burst_end, line_end;
   logic [9:0]  col_d, wcnt_d;
   logic [6:0]  bcnt_d;

`ifdef LINE_FETCH_CDC_EN
   logic [1:0] req_sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_sync_q <= 2'b00;
      end else begin
         req_sync_q <= {req_sync_q[0], g_req};
      end
   end

   assign req_s = req_sync_q[1];
`else
   assign req_s = g_req;
`endif

   assign pending     = (req_s != g_ack_q);
   // Only words arriving while a burst is outstanding are taken; anything else is dropped.
   assign word_accept = (state_q == ST_WAIT) && sd_rd_valid;
   assign burst_end   = word_accept && (bcnt_q == BURST_LAST);
   // The word being accepted now is the last of the line.
   assign line_end    = (({1'b0, wcnt_q} + 11'd1) == LINE_WORDS_W);
   assign col_d       = col_q + BURST_STEP;
   assign wcnt_d      = wcnt_q + 10'd1;
   assign bcnt_d      = bcnt_q + 7'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         g_ack_q      <= 1'b0;
         ack_val_q    <= 1'b0;
         row_sel_q    <= 1'b0;
         busy_q       <= 1'b0;
         sd_rd_req_q  <= 1'b0;
         wr_en_q      <= 1'b0;
         row_addr_q   <= '0;
         col_q        <= '0;
         wcnt_q       <= '0;
         bcnt_q       <= '0;
         sd_addr_q    <= '0;
         wr_address_q <= '0;
         wr_data_q    <= '0;
      end else begin
         wr_en_q <= 1'b0;

         // Write path: one cycle behind the accepted read word.
         if (word_accept && (bcnt_q <= BURST_LAST)) begin
            wr_en_q      <= 1'b1;
            wr_address_q <= {row_sel_q, wcnt_q};
            wr_data_q    <= sd_rd_data;
            wcnt_q       <= wcnt_d;
            bcnt_q       <= bcnt_d;
         end

         case (state_q)
            ST_IDLE: begin
               if (pending) begin
                  ack_val_q   <= req_s;
                  row_sel_q   <= g_cache_row;
                  row_addr_q  <= g_sdram_row;
                  col_q       <= '0;
                  wcnt_q      <= '0;
                  busy_q      <= 1'b1;
                  sd_rd_req_q <= 1'b1;
                  sd_addr_q   <= {g_sdram_row, 10'd0};
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sd_rd_ack) begin
                  sd_rd_req_q <= 1'b0;
                  col_q       <= col_d;
                  bcnt_q      <= '0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (burst_end) begin
                  if (line_end) begin
                     state_q <= ST_DONE;
                  end else begin
                     // col_q already points past the burst just completed.
                     sd_rd_req_q <= 1'b1;
                     sd_addr_q   <= {row_addr_q, col_q};
                     state_q     <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               // The last write strobe is on the cycle before this edge, so the line is
               // complete in the cache by the time g_ack toggles.
               g_ack_q <= ack_val_q;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign g_ack      = g_ack_q;
   assign busy       = busy_q;
   assign sd_rd_req  = sd_rd_req_q;
   assign sd_addr    = sd_addr_q;
   assign wr_en      = wr_en_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// tb/tb_vga_line_fetcher.sv - randomized self-checking bench for vga_line_fetcher
module tb_vga_line_fetcher;

   localparam int LW = 752;
   localparam int BL = 8;
   localparam int NB = LW / BL;
`ifdef LINE_FETCH_CDC_EN
   localparam int ACC_LAT = 3;
`else
   localparam int ACC_LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        g_req = 1'b0;
   logic        g_ack;
   logic        g_cache_row = 1'b0;
   logic [9:0]  g_sdram_row = '0;
   logic        sd_rd_req;
   logic        sd_rd_ack = 1'b0;
   logic [19:0] sd_addr;
   logic        sd_rd_valid = 1'b0;
   logic [15:0] sd_rd_data = '0;
   logic        wr_en;
   logic [10:0] wr_address;
   logic [15:0] wr_data;
   logic        busy;

   vga_line_fetcher #(.LINE_WORDS(LW), .BURST_LEN(BL)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .g_req       (g_req),
      .g_ack       (g_ack),
      .g_cache_row (g_cache_row),
      .g_sdram_row (g_sdram_row),
      .sd_rd_req   (sd_rd_req),
      .sd_rd_ack   (sd_rd_ack),
      .sd_addr     (sd_addr),
      .sd_rd_valid (sd_rd_valid),
      .sd_rd_data  (sd_rd_data),
      .wr_en       (wr_en),
      .wr_address  (wr_address),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] salt;
   logic [26:0] exp_wr_q[$];
   logic [26:0] got_wr_q[$];
   logic [19:0] exp_bu_q[$];
   logic [19:0] got_bu_q[$];

   // SDRAM responder state
   int          words_left = 0;
   int          wpos = 0;
   int          stall_left = 0;
   bit          stall_next = 0;
   bit          extra_pend = 0;
   bit          spur_en = 1;
   logic [19:0] cur_addr = '0;
   logic [19:0] stall_addr = '0;

   // Monitor state
   int   last_wr_cyc = 0;
   int   ack_cyc = 0;
   logic prev_ack = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Content of SDRAM at (row, col): an arbitrary salted hash.
   function automatic logic [15:0] mem_word(input logic [9:0] row, input logic [9:0] col);
      logic [31:0] v;
      v = ({22'd0, row} * 32'h0000_9E37) ^ ({22'd0, col} * 32'h0000_03B1) ^ salt;
      return v[15:0];
   endfunction

   // Reference: a line is LW consecutive words of the row, written in column order into the half.
   task automatic expect_line(input logic cr, input logic [9:0] row);
      for (int i = 0; i < LW; i++) exp_wr_q.push_back({cr, 10'(i), mem_word(row, 10'(i))});
      for (int b = 0; b < NB; b++) exp_bu_q.push_back({row, 10'(b * BL)});
   endtask

   // SDRAM controller model
   initial begin
      forever begin
         @(negedge clk);
         sd_rd_ack   = 1'b0;
         sd_rd_valid = 1'b0;
         if (!reset_n) begin
            words_left = 0;
            extra_pend = 0;
            stall_left = 0;
         end else if (stall_left > 0) begin
            check_eq("stall_req", 32'(sd_rd_req), 32'd1);
            check_eq("stall_addr", 32'(sd_addr), 32'(stall_addr));
            check_eq("stall_wr_en", 32'(wr_en), 32'd0);
            stall_left--;
         end else if (words_left > 0) begin
            if ($urandom_range(0, 3) != 0) begin
               sd_rd_valid = 1'b1;
               sd_rd_data  = mem_word(cur_addr[19:10], cur_addr[9:0] + 10'(wpos));
               wpos++;
               words_left--;
               if (words_left == 0 && spur_en && $urandom_range(0, 1) == 1) extra_pend = 1;
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
               sd_rd_ack = 1'b1;  // stray ack with no request outstanding
            end
         end else if (extra_pend) begin
            sd_rd_valid = 1'b1;
            sd_rd_data  = 16'hDEAD;
            extra_pend  = 0;
         end else if (sd_rd_req) begin
            if (stall_next) begin
               stall_next = 0;
               stall_addr = sd_addr;
               stall_left = 20;
            end else if ($urandom_range(0, 1) == 1) begin
               sd_rd_ack = 1'b1;
               got_bu_q.push_back(sd_addr);
               cur_addr   = sd_addr;
               words_left = BL;
               wpos       = 0;
            end
         end else if (spur_en && !busy && $urandom_range(0, 7) == 0) begin
            sd_rd_valid = 1'b1;
            sd_rd_data  = 16'hBEEF;
         end
      end
   end

   // Line cache write / ack monitor
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && wr_en) begin
            got_wr_q.push_back({wr_address, wr_data});
            last_wr_cyc = cyc;
         end
         if (g_ack !== prev_ack) begin
            ack_cyc  = cyc;
            prev_ack = g_ack;
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_g_ack"}, 32'(g_ack), 32'd0);
      check_eq({tag, "_sd_rd_req"}, 32'(sd_rd_req), 32'd0);
      check_eq({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
      check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check_eq({tag, "_wr_address"}, 32'(wr_address), 32'd0);
      check_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic start_req(input logic cr, input logic [9:0] row);
      @(negedge clk);
      g_cache_row = cr;
      g_sdram_row = row;
      g_req       = ~g_req;
   endtask

   task automatic wait_ack(input logic v, input string tag);
      int n;
      n = 0;
      while (g_ack !== v && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(g_ack), 32'(v));
   endtask

   task automatic compare_lines(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_ack_after_last_wr"}, 32'(last_wr_cyc < ack_cyc), 32'd1);
      check_eq({tag, "_n_bursts"}, 32'(got_bu_q.size()), 32'(exp_bu_q.size()));
      for (int i = 0; i < exp_bu_q.size() && i < got_bu_q.size(); i++)
         check_eq($sformatf("%s_burst%0d", tag, i), 32'(got_bu_q[i]), 32'(exp_bu_q[i]));
      check_eq({tag, "_n_writes"}, 32'(got_wr_q.size()), 32'(exp_wr_q.size()));
      for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
         check_eq($sformatf("%s_wr%0d", tag, i), 32'(got_wr_q[i]), 32'(exp_wr_q[i]));
      exp_wr_q.delete();
      got_wr_q.delete();
      exp_bu_q.delete();
      got_bu_q.delete();
   endtask

   initial begin
      int lat;
      int act;
      logic       cr;
      logic [9:0] row;
      salt = $urandom;

      // Reset state
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_outputs_zero("idle");

      // Single line with acceptance latency
      expect_line(1'b1, 10'h05A);
      start_req(1'b1, 10'h05A);
      lat = 0;
      while (!sd_rd_req && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check_eq("accept_latency", 32'(lat), 32'(ACC_LAT));
      wait_ack(1'b1, "line1_ack");
      compare_lines("line1");

      // Controller stall on the first burst
      row = 10'($urandom);
      expect_line(1'b0, row);
      stall_next = 1;
      start_req(1'b0, row);
      wait_ack(1'b0, "stall_ack");
      compare_lines("stall");

      // Back-to-back: second toggle while the first line is still busy
      expect_line(1'b1, 10'h05A);
      expect_line(1'b0, 10'h05B);
      start_req(1'b1, 10'h05A);
      repeat (60) @(negedge clk);
      check_eq("b2b_busy_mid", 32'(busy), 32'd1);
      start_req(1'b0, 10'h05B);
      wait_ack(1'b1, "b2b_ack1");
      wait_ack(1'b0, "b2b_ack2");
      compare_lines("b2b");

      // Random lines
      for (int k = 0; k < 2; k++) begin
         cr  = 1'($urandom);
         row = 10'($urandom);
         expect_line(cr, row);
         start_req(cr, row);
         wait_ack(~g_ack, $sformatf("rand%0d_ack", k));
         compare_lines($sformatf("rand%0d", k));
      end

      // Asynchronous reset in the middle of a line
      start_req(1'b1, 10'($urandom));
      repeat (100) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      g_req = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      act = 0;
      repeat (30) begin
         @(negedge clk);
         if (sd_rd_req || wr_en || busy || g_ack) act++;
      end
      check_eq("post_reset_activity", 32'(act), 32'd0);
      exp_wr_q.delete();
      got_wr_q.delete();
      exp_bu_q.delete();
      got_bu_q.delete();

      // Fresh line after the reset
      row = 10'($urandom);
      expect_line(1'b0, row);
      start_req(1'b0, row);
      wait_ack(1'b1, "post_reset_ack");
      compare_lines("post_reset");

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
